// File: rtl/priv_trap_unit.sv
// Privilege/trap controller: owns the trap CSRs, prioritises trap/mret/sret/CSR-write
// each cycle and issues a registered one-cycle fetch redirect.
module priv_trap_unit #(
  parameter int N        = 64,
  parameter int NCAUSE   = 16,
  parameter int SMODE_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCAUSE-1:0] trapTrigger,
  input  logic [N-1:0]      trapPC,
  input  logic              trapReturn,
  input  logic              trapReturnS,
  input  logic              csrWriteEnable,
  input  logic [11:0]       csrAddr,
  input  logic [N-1:0]      csrIn,
  output logic [N-1:0]      csrOut,
  output logic [1:0]        currentMode,
  output logic [N-1:0]      mstatus,
  output logic              redirectValid,
  output logic [N-1:0]      redirectPC
);

  localparam logic [1:0] MODE_M = 2'b11;
  localparam logic [1:0] MODE_S = 2'b01;
  localparam logic [1:0] MODE_U = 2'b00;

  localparam int SIE  = 1;
  localparam int MIE  = 3;
  localparam int SPIE = 5;
  localparam int MPIE = 7;
  localparam int SPP  = 8;

  localparam bit S_EN = (SMODE_EN != 0);

  // Truncation to 32 bits leaves UXL-style reset bit out, giving 0 for N = 32.
  localparam logic [N-1:0] MSTATUS_RST = N'(64'h0000_0002_0000_0000);
  localparam logic [N-1:0] M_WMASK     = N'(S_EN ? 64'h19AA : 64'h1888);
  localparam logic [N-1:0] S_MASK      = N'(S_EN ? 64'h0122 : 64'h0000);
  localparam logic [N-1:0] DELEG_MASK  = S_EN ? N'((65'd1 << NCAUSE) - 65'd1) : '0;
  localparam logic [N-1:0] ALIGN_MASK  = {{(N-2){1'b1}}, 2'b00};

  logic [1:0]   mode_q, mode_d;
  logic [N-1:0] mstatus_q, mstatus_d;
  logic [N-1:0] medeleg_q, medeleg_d;
  logic [N-1:0] mtvec_q, mtvec_d;
  logic [N-1:0] stvec_q, stvec_d;
  logic [N-1:0] mepc_q, mepc_d;
  logic [N-1:0] sepc_q, sepc_d;
  logic [N-1:0] mcause_q, mcause_d;
  logic [N-1:0] scause_q, scause_d;
  logic         redirect_valid_q, redirect_valid_d;
  logic [N-1:0] redirect_pc_q, redirect_pc_d;

  logic         trap_any;
  logic [N-1:0] cause;
  logic         cause_deleg;
  logic         delegate;
  logic [1:0]   mpp_w;

  always_comb begin
    mode_d           = mode_q;
    mstatus_d        = mstatus_q;
    medeleg_d        = medeleg_q;
    mtvec_d          = mtvec_q;
    stvec_d          = stvec_q;
    mepc_d           = mepc_q;
    sepc_d           = sepc_q;
    mcause_d         = mcause_q;
    scause_d         = scause_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    // Descending scan so the lowest set index wins.
    trap_any    = |trapTrigger;
    cause       = '0;
    cause_deleg = 1'b0;
    for (int i = NCAUSE - 1; i >= 0; i--) begin
      if (trapTrigger[i]) begin
        cause       = N'(i);
        cause_deleg = medeleg_q[i];
      end
    end
    delegate = S_EN && (mode_q != MODE_M) && cause_deleg;

    mpp_w = csrIn[12:11];
    if (mpp_w == 2'b10 || (!S_EN && mpp_w == MODE_S))
      mpp_w = MODE_U;

    if (trap_any) begin
      redirect_valid_d = 1'b1;
      if (delegate) begin
        redirect_pc_d   = stvec_q;
        scause_d        = cause;
        sepc_d          = trapPC & ALIGN_MASK;
        mstatus_d[SPP]  = mode_q[0];
        mstatus_d[SPIE] = mstatus_q[SIE];
        mstatus_d[SIE]  = 1'b0;
        mode_d          = MODE_S;
      end else begin
        redirect_pc_d     = mtvec_q;
        mcause_d          = cause;
        mepc_d            = trapPC & ALIGN_MASK;
        mstatus_d[12:11]  = mode_q;
        mstatus_d[MPIE]   = mstatus_q[MIE];
        mstatus_d[MIE]    = 1'b0;
        mode_d            = MODE_M;
      end
    end else if (trapReturn) begin
      redirect_valid_d = 1'b1;
      redirect_pc_d    = mepc_q;
      mode_d           = mstatus_q[12:11];
      mstatus_d[MIE]   = mstatus_q[MPIE];
      mstatus_d[MPIE]  = 1'b1;
      mstatus_d[12:11] = MODE_U;
    end else if (trapReturnS) begin
      // An sret from U or on an M/U-only core is a no-op; the decoder flags it.
      if (S_EN && mode_q != MODE_U) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = sepc_q;
        mode_d           = {1'b0, mstatus_q[SPP]};
        mstatus_d[SIE]   = mstatus_q[SPIE];
        mstatus_d[SPIE]  = 1'b1;
        mstatus_d[SPP]   = 1'b0;
      end
    end else if (csrWriteEnable) begin
      case (csrAddr)
        12'h300: begin
          mstatus_d        = (mstatus_q & ~M_WMASK) | (csrIn & M_WMASK);
          mstatus_d[12:11] = mpp_w;
        end
        12'h302: medeleg_d = csrIn & DELEG_MASK;
        12'h305: mtvec_d   = csrIn & ALIGN_MASK;
        12'h341: mepc_d    = csrIn & ALIGN_MASK;
        12'h342: mcause_d  = csrIn;
        12'h100: if (S_EN) mstatus_d = (mstatus_q & ~S_MASK) | (csrIn & S_MASK);
        12'h105: if (S_EN) stvec_d   = csrIn & ALIGN_MASK;
        12'h141: if (S_EN) sepc_d    = csrIn & ALIGN_MASK;
        12'h142: if (S_EN) scause_d  = csrIn;
        default: ;
      endcase
    end
  end

  always_comb begin
    csrOut = '0;
    case (csrAddr)
      12'h300: csrOut = mstatus_q;
      12'h302: csrOut = medeleg_q;
      12'h305: csrOut = mtvec_q;
      12'h341: csrOut = mepc_q;
      12'h342: csrOut = mcause_q;
      12'h100: csrOut = mstatus_q & S_MASK;
      12'h105: csrOut = stvec_q;
      12'h141: csrOut = sepc_q;
      12'h142: csrOut = scause_q;
      default: csrOut = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q           <= MODE_M;
      mstatus_q        <= MSTATUS_RST;
      medeleg_q        <= '0;
      mtvec_q          <= '0;
      stvec_q          <= '0;
      mepc_q           <= '0;
      sepc_q           <= '0;
      mcause_q         <= '0;
      scause_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mode_q           <= mode_d;
      mstatus_q        <= mstatus_d;
      medeleg_q        <= medeleg_d;
      mtvec_q          <= mtvec_d;
      stvec_q          <= stvec_d;
      mepc_q           <= mepc_d;
      sepc_q           <= sepc_d;
      mcause_q         <= mcause_d;
      scause_q         <= scause_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign currentMode   = mode_q;
  assign mstatus       = mstatus_q;
  assign redirectValid = redirect_valid_q;
  assign redirectPC    = redirect_pc_q;

endmodule

// File: tb/tb_priv_trap_unit.sv
// Drives an S-capable and an M/U-only instance with identical stimulus; a field-level
// model predicts CSRs and redirects, and a monitor pops expected redirects from queues.
module tb_priv_trap_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] trapTrigger;
  logic [63:0] trapPC;
  logic        trapReturn, trapReturnS, csrWriteEnable;
  logic [11:0] csrAddr;
  logic [63:0] csrIn;

  logic [63:0] csrOut0, mstatus0, rpc0, csrOut1, mstatus1, rpc1;
  logic [1:0]  mode0, mode1;
  logic        rv0, rv1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  priv_trap_unit #(.N(64), .NCAUSE(16), .SMODE_EN(1)) u0 (
    .clk(clk), .reset(reset), .trapTrigger(trapTrigger), .trapPC(trapPC),
    .trapReturn(trapReturn), .trapReturnS(trapReturnS), .csrWriteEnable(csrWriteEnable),
    .csrAddr(csrAddr), .csrIn(csrIn), .csrOut(csrOut0), .currentMode(mode0),
    .mstatus(mstatus0), .redirectValid(rv0), .redirectPC(rpc0));

  priv_trap_unit #(.N(64), .NCAUSE(16), .SMODE_EN(0)) u1 (
    .clk(clk), .reset(reset), .trapTrigger(trapTrigger), .trapPC(trapPC),
    .trapReturn(trapReturn), .trapReturnS(trapReturnS), .csrWriteEnable(csrWriteEnable),
    .csrAddr(csrAddr), .csrIn(csrIn), .csrOut(csrOut1), .currentMode(mode1),
    .mstatus(mstatus1), .redirectValid(rv1), .redirectPC(rpc1));

  typedef struct {
    bit          smode;
    logic [1:0]  mode, mpp;
    bit          sie, mie, spie, mpie, spp;
    logic [63:0] medeleg, mtvec, stvec, mepc, sepc, mcause, scause;
  } model_t;

  model_t m0, m1;
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic mreset(inout model_t m);
    m.mode = 2'b11; m.mpp = 2'b00;
    m.sie = 0; m.mie = 0; m.spie = 0; m.mpie = 0; m.spp = 0;
    m.medeleg = 0; m.mtvec = 0; m.stvec = 0; m.mepc = 0; m.sepc = 0;
    m.mcause = 0; m.scause = 0;
  endtask

  function automatic logic [63:0] m_mstatus(input model_t m);
    return 64'h2_0000_0000 | (64'(m.sie) << 1) | (64'(m.mie) << 3) | (64'(m.spie) << 5) |
           (64'(m.mpie) << 7) | (64'(m.spp) << 8) | (64'(m.mpp) << 11);
  endfunction

  function automatic logic [63:0] m_read(input model_t m, input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus(m);
      12'h302: return m.medeleg;
      12'h305: return m.mtvec;
      12'h341: return m.mepc;
      12'h342: return m.mcause;
      12'h100: return m.smode ? ((64'(m.sie) << 1) | (64'(m.spie) << 5) | (64'(m.spp) << 8)) : 64'h0;
      12'h105: return m.stvec;
      12'h141: return m.sepc;
      12'h142: return m.scause;
      default: return 64'h0;
    endcase
  endfunction

  task automatic step(inout model_t m, input logic [15:0] trig, input logic [63:0] pc,
                      input bit ret, input bit rets, input bit we, input logic [11:0] a,
                      input logic [63:0] din, output bit rv, output logic [63:0] rpc);
    int c;
    logic [1:0] w;
    rv = 0; rpc = 0;
    if (trig != 0) begin
      c = 0;
      while (!trig[c]) c++;
      rv = 1;
      if (m.smode && m.mode != 2'b11 && m.medeleg[c]) begin
        rpc = m.stvec; m.scause = 64'(c); m.sepc = pc & ~64'h3;
        m.spp = m.mode[0]; m.spie = m.sie; m.sie = 0; m.mode = 2'b01;
      end else begin
        rpc = m.mtvec; m.mcause = 64'(c); m.mepc = pc & ~64'h3;
        m.mpp = m.mode; m.mpie = m.mie; m.mie = 0; m.mode = 2'b11;
      end
    end else if (ret) begin
      rv = 1; rpc = m.mepc;
      m.mode = m.mpp; m.mie = m.mpie; m.mpie = 1; m.mpp = 2'b00;
    end else if (rets) begin
      if (m.smode && m.mode != 2'b00) begin
        rv = 1; rpc = m.sepc;
        m.mode = {1'b0, m.spp}; m.sie = m.spie; m.spie = 1; m.spp = 0;
      end
    end else if (we) begin
      case (a)
        12'h300: begin
          w = din[12:11];
          if (w == 2'b10 || (!m.smode && w == 2'b01)) w = 2'b00;
          m.mie = din[3]; m.mpie = din[7]; m.mpp = w;
          if (m.smode) begin m.sie = din[1]; m.spie = din[5]; m.spp = din[8]; end
        end
        12'h302: if (m.smode) m.medeleg = din & 64'hFFFF;
        12'h305: m.mtvec = din & ~64'h3;
        12'h341: m.mepc = din & ~64'h3;
        12'h342: m.mcause = din;
        12'h100: if (m.smode) begin m.sie = din[1]; m.spie = din[5]; m.spp = din[8]; end
        12'h105: if (m.smode) m.stvec = din & ~64'h3;
        12'h141: if (m.smode) m.sepc = din & ~64'h3;
        12'h142: if (m.smode) m.scause = din;
        default: ;
      endcase
    end
  endtask

  task automatic check_state();
    chk("mode0", 64'(mode0), 64'(m0.mode));
    chk("mstatus0", mstatus0, m_mstatus(m0));
    chk("csrOut0", csrOut0, m_read(m0, csrAddr));
    chk("mode1", 64'(mode1), 64'(m1.mode));
    chk("mstatus1", mstatus1, m_mstatus(m1));
    chk("csrOut1", csrOut1, m_read(m1, csrAddr));
  endtask

  task automatic cyc(input logic [15:0] trig, input logic [63:0] pc, input bit ret,
                     input bit rets, input bit we, input logic [11:0] a, input logic [63:0] din);
    bit rv;
    logic [63:0] rpc;
    @(negedge clk);
    trapTrigger = trig; trapPC = pc; trapReturn = ret; trapReturnS = rets;
    csrWriteEnable = we; csrAddr = a; csrIn = din;
    #1;
    check_state();
    step(m0, trig, pc, ret, rets, we, a, din, rv, rpc);
    if (rv) q0.push_back(rpc);
    step(m1, trig, pc, ret, rets, we, a, din, rv, rpc);
    if (rv) q1.push_back(rpc);
  endtask

  task automatic idle(input logic [11:0] a);
    cyc(16'h0, 64'h0, 0, 0, 0, a, 64'h0);
  endtask

  // Redirect monitor, decoupled from stimulus.
  always @(posedge clk) begin
    #1;
    if (rv0) begin
      if (q0.size() == 0) chk("redirect0_unexpected", 64'(rv0), 64'h0);
      else chk("redirect0_pc", rpc0, q0.pop_front());
    end
    if (rv1) begin
      if (q1.size() == 0) chk("redirect1_unexpected", 64'(rv1), 64'h0);
      else chk("redirect1_pc", rpc1, q1.pop_front());
    end
  end

  logic [11:0] addrs [11] = '{12'h300, 12'h302, 12'h305, 12'h341, 12'h342,
                              12'h100, 12'h105, 12'h141, 12'h142, 12'h344, 12'h000};

  initial begin
    logic [15:0] trig;
    bit ret, rets, we;
    m0.smode = 1; m1.smode = 0;
    mreset(m0); mreset(m1);
    reset = 1; trapTrigger = 0; trapPC = 0; trapReturn = 0; trapReturnS = 0;
    csrWriteEnable = 0; csrAddr = 0; csrIn = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      csrAddr = addrs[i];
      #1;
      chk("reset_csr0", csrOut0, (addrs[i] == 12'h300) ? 64'h2_0000_0000 : 64'h0);
      chk("reset_csr1", csrOut1, (addrs[i] == 12'h300) ? 64'h2_0000_0000 : 64'h0);
    end
    chk("reset_mode0", 64'(mode0), 64'h3);
    chk("reset_rv0", 64'(rv0), 64'h0);
    @(negedge clk);
    reset = 0;

    // M-mode trap
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h305, 64'h1000);
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h300, 64'h8);
    cyc(16'h0024, 64'h80, 0, 0, 0, 12'h342, 64'h0);
    idle(12'h342);
    chk("mtrap_mcause", csrOut0, 64'h2);
    idle(12'h300);
    chk("mtrap_mstatus", mstatus0, 64'h2_0000_1880);

    // Delegation to S, then sret
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h302, 64'h100);
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h105, 64'h2000);
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h300, 64'h2);
    cyc(16'h0, 64'h0, 1, 0, 0, 12'h300, 64'h0);
    cyc(16'h0100, 64'h300, 0, 0, 0, 12'h142, 64'h0);
    idle(12'h142);
    chk("deleg_scause", csrOut0, 64'h8);
    chk("deleg_mode0", 64'(mode0), 64'h1);
    chk("nodeleg_mode1", 64'(mode1), 64'h3);
    cyc(16'h0, 64'h0, 0, 1, 0, 12'h100, 64'h0);
    idle(12'h100);
    chk("sret_sstatus", csrOut0, 64'h22);
    chk("sret_mode0", 64'(mode0), 64'h0);
    chk("sret_ignored_mode1", 64'(mode1), 64'h3);
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h302, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(12'h302);
    chk("medeleg_ones0", csrOut0, 64'hFFFF);
    chk("medeleg_ones1", csrOut1, 64'h0);

    // mret with MPP WARL
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h302, 64'h0);
    cyc(16'h0001, 64'h400, 0, 0, 0, 12'h300, 64'h0);
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h300, 64'h1000);
    idle(12'h300);
    chk("mpp_warl10", (csrOut0 >> 11) & 64'h3, 64'h0);
    cyc(16'h0, 64'h0, 0, 0, 1, 12'h300, 64'h880);
    cyc(16'h0, 64'h0, 1, 0, 0, 12'h300, 64'h0);
    idle(12'h300);
    chk("mret_mode0", 64'(mode0), 64'h1);
    chk("mret_mode1", 64'(mode1), 64'h0);

    // Trap + mret + mtvec write in one cycle
    cyc(16'h0010, 64'h500, 1, 0, 1, 12'h305, 64'h0999_9000);
    idle(12'h305);
    chk("simul_mtvec", csrOut0, 64'h1000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      trig = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      ret  = ($urandom_range(0, 7) == 0);
      rets = ($urandom_range(0, 7) == 0);
      we   = !rets && ($urandom_range(0, 1) == 1);
      cyc(trig, {$urandom, $urandom}, ret, rets, we, addrs[$urandom_range(0, 10)],
          {$urandom, $urandom});
    end
    idle(12'h300);
    idle(12'h300);

    // Reset asserted while a redirect pulse is high
    cyc(16'h0002, 64'h600, 0, 0, 0, 12'h300, 64'h0);
    @(posedge clk);
    #2;
    chk("pre_reset_rv0", 64'(rv0), 64'h1);
    reset = 1;
    trapTrigger = 0; trapReturn = 0; trapReturnS = 0; csrWriteEnable = 0;
    #1;
    chk("async_reset_rv0", 64'(rv0), 64'h0);
    chk("async_reset_rv1", 64'(rv1), 64'h0);
    chk("async_reset_mode0", 64'(mode0), 64'h3);
    chk("async_reset_mstatus0", mstatus0, 64'h2_0000_0000);
    mreset(m0); mreset(m1);
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    idle(12'h341);
    idle(12'h342);
    repeat (2) @(negedge clk);
    chk("queue0_drained", 64'(q0.size()), 64'h0);
    chk("queue1_drained", 64'(q1.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priv_trap_unit.md
# priv_trap_unit

Parametrised privilege and trap controller for the core, handling Machine, Supervisor and User modes. It owns the trap-related CSRs: mstatus/sstatus view, medeleg, mtvec, stvec, mepc, sepc, mcause and scause. It performs prioritised trap entry with optional S-mode delegation, executes mret/sret, and issues a registered one-cycle fetch redirect to the front end. It sits beside the CSR file and is driven by the decode/execute trap logic.

## Interface
- N, 64: data width; must be 32 or 64.
- NCAUSE, 16: number of synchronous exception causes; must be ≤ N.
- SMODE_EN, 1: 1 implements S-mode and delegation; 0 gives an M/U-only core.

- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- trapTrigger  in  NCAUSE  exception request vector, one bit per cause index.
- trapPC  in  N  PC of the faulting instruction.
- trapReturn  in  1  mret retiring.
- trapReturnS  in  1  sret retiring.
- csrWriteEnable  in  1  CSR write strobe.
- csrAddr  in  12  CSR address for both read and write.
- csrIn  in  N  CSR write data.
- csrOut  out  N  combinational read of csrAddr; 0 for unowned addresses.
- currentMode  out  2  privilege mode: 11 = M, 01 = S, 00 = U.
- mstatus  out  N  full mstatus register.
- redirectValid  out  1  one-cycle fetch redirect pulse.
- redirectPC  out  N  redirect target.

## Operation
- Owned CSR addresses:
  - mstatus 0x300, medeleg 0x302, mtvec 0x305, mepc 0x341, mcause 0x342.
  - sstatus 0x100, stvec 0x105, sepc 0x141, scause 0x142.
- sstatus is a masked view of mstatus. Only SIE (bit 1), SPIE (5) and SPP (8) are readable and writable through it.
- Writable mstatus fields are SIE (1), MIE (3), SPIE (5), MPIE (7), SPP (8) and MPP (12:11). All other bits hold their reset value.
- WARL rules:
  - MPP written as 10 stores 00.
  - When SMODE_EN = 0: MPP written as 01 stores 00; SIE, SPIE and SPP read 0; the S-mode CSRs and medeleg read 0 and ignore writes.
  - Bits [1:0] of mtvec, stvec, mepc and sepc always read 0.
  - medeleg bits at index NCAUSE and above read 0.
- Event priority within a cycle, highest first: trap, then trapReturn, then trapReturnS, then CSR write. Lower-priority events in the same cycle are dropped entirely.
- Trap entry, when any trapTrigger bit is set:
  - Cause c is the lowest set index.
  - The trap is delegated when SMODE_EN = 1, currentMode ≠ 11 and medeleg[c] = 1.
  - Delegated trap: scause = c; sepc = trapPC; SPP = currentMode[0]; SPIE = SIE; SIE = 0; mode becomes 01; redirectPC = stvec.
  - Non-delegated trap: mcause = c; mepc = trapPC; MPP = currentMode; MPIE = MIE; MIE = 0; mode becomes 11; redirectPC = mtvec.
  - cause values are zero-extended, with the interrupt bit (N-1) = 0.
- mret (trapReturn):
  - mode = MPP; MIE = MPIE; MPIE = 1; MPP = 00; redirectPC = mepc.
- sret (trapReturnS):
  - Honoured only when currentMode ≠ 00 and SMODE_EN = 1. Otherwise it is ignored: no state change and no redirect. The decoder is responsible for raising illegal-instruction.
  - When honoured: mode = {0, SPP}; SIE = SPIE; SPIE = 1; SPP = 0; redirectPC = sepc.
- redirectPC uses the tvec/epc values from before the update edge. A trap that writes mepc does not affect its own redirect target.

## Timing
- All state is updated on the rising edge of clk.
- csrOut is combinational and reflects new values the cycle after the update edge.
- redirectValid and redirectPC are registered. redirectValid is high for exactly the one cycle following an accepted trap or return. Back-to-back events give back-to-back pulses.
- Reset values:
  - currentMode = 11.
  - mstatus = 0x0000000200000000 when N = 64, 0 when N = 32.
  - All other CSRs = 0.
  - redirectValid = 0, redirectPC = 0.
- Reset asserted mid-redirect clears redirectValid immediately and asynchronously.

## Test plan
- **Reset:** assert reset with redirectValid high → currentMode = 11, mstatus = 0x200000000, redirectValid = 0 without waiting for a clock edge; all other CSRs read 0.
- **M-mode trap:** mtvec = 0x1000, MIE = 1, mode M, trapTrigger = 0x0024, trapPC = 0x80 → mcause = 2, mepc = 0x80, MPP = 11, MPIE = 1, MIE = 0; redirect pulse to 0x1000 the next cycle.
- **Delegation and sret:** medeleg = 0x0100, stvec = 0x2000, SIE = 1, mode U, trapTrigger bit 8 → scause = 8, SPP = 0, SPIE = 1, SIE = 0, mode = 01, redirect to 0x2000. A following sret → mode = 00, SIE = 1, redirect to sepc.
- **mret WARL:** write MPP = 10 → reads 00. Set MPP = 01, MPIE = 1, then mret → mode = 01, MIE = 1, MPP = 00, redirect to mepc.
- **Simultaneous events:** trap, mret and a CSR write to mtvec in the same cycle → only the trap takes effect; mtvec is unchanged; redirect target is the old mtvec.
- **SMODE_EN = 0:** medeleg write of all-ones reads 0; trap taken from U mode goes to M; sret is ignored with no redirect.
